letter_uart_tx: RTL and testbench

Downstream consumer of the 8-bit letter stream produced by the generated `_helloWorld` character source. It buffers letters in a small FIFO and serializes each one onto a UART-style 8N1 line. `_ready` is wired back to the source's `_enable` so the source only advances when a letter can be accepted. The block sits between the character generator and the board's serial pin.

---
 rtl/letter_uart_tx.sv | 131 +++++++++++++
 tb/tb_letter_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/letter_uart_tx.sv
// rtl/letter_uart_tx.sv - letter FIFO feeding an 8N1 serializer
// Letters queue in a small FIFO; each is sent LSB first framed by start/stop bits.
module letter_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  _clock,
  input  logic                  _reset,
  input  logic                  _valid,
  input  logic [7:0]            _letter,
  output logic                  _ready,
  output logic                  _tx,
  output logic                  _busy,
  output logic [DEPTH_LOG2:0]   _count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic [BW-1:0]         baud, baud_next;
  logic [2:0]            bit_cnt, bit_next;
  logic [7:0]            shift, shift_next;
  logic                  tx_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop, baud_end, have_letter;

  assign _ready      = (_count != (DEPTH_LOG2 + 1)'(DEPTH));
  assign push        = _valid && _ready;
  assign have_letter = (_count != '0);
  assign baud_end    = (baud == BW'(CLKS_PER_BIT - 1));
  assign _busy       = (state != IDLE) || have_letter;

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    shift_next = shift;
    tx_next    = _tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        if (have_letter) begin
          shift_next = mem[rd_ptr];
          pop        = 1'b1;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          tx_next    = shift[0];
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            shift_next = shift >> 1;
            tx_next    = shift[1];
            bit_next   = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (have_letter) begin
            shift_next = mem[rd_ptr];
            pop        = 1'b1;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      _tx     <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      _count  <= '0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      _tx     <= tx_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      _count  <= _count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  always_ff @(posedge _clock) begin
    if (push) mem[wr_ptr] <= _letter;
  end

endmodule

// File: tb/tb_letter_uart_tx.sv
// tb/tb_letter_uart_tx.sv - randomized and directed checks of letter_uart_tx
// A queue-and-frame-timer model predicts every output cycle by cycle.
module tb_letter_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, valid1;
  logic [7:0] letter, letter1;
  logic       ready, tx, busy, ready1, tx1, busy1;
  logic [2:0] count, count1;

  always #5 clk = ~clk;

  letter_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(2)) dut (
    ._clock(clk), ._reset(rst), ._valid(valid), ._letter(letter),
    ._ready(ready), ._tx(tx), ._busy(busy), ._count(count)
  );

  letter_uart_tx #(.CLKS_PER_BIT(1), .DEPTH_LOG2(2)) dut1 (
    ._clock(clk), ._reset(rst), ._valid(valid1), ._letter(letter1),
    ._ready(ready1), ._tx(tx1), ._busy(busy1), ._count(count1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: letters waiting in a queue, plus the frame on the wire and how far into it we are.
  int         q[$];
  int         sent[$];
  bit         fr_on = 1'b0;
  int         fr_t = 0;
  logic [7:0] fr_byte = 8'h00;
  int         m_cnt;
  bit         m_end;
  int         cyc = 0;

  function automatic logic m_tx();
    int idx;
    if (!fr_on) return 1'b1;
    idx = fr_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fr_byte[idx-1];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      fr_on = 1'b0;
      fr_t  = 0;
    end else begin
      m_cnt = q.size();
      m_end = fr_on && (fr_t == 10*CPB - 1);
      if ((!fr_on || m_end) && m_cnt > 0) begin
        fr_byte = 8'(q.pop_front());
        fr_on   = 1'b1;
        fr_t    = 0;
        sent.push_back(int'(fr_byte));
      end else if (m_end) begin
        fr_on = 1'b0;
      end else if (fr_on) begin
        fr_t++;
      end
      if (valid && m_cnt != DEPTH) q.push_back(int'(letter));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("tx", tx, m_tx());
      chk("ready", ready, q.size() != DEPTH);
      chk("busy", busy, fr_on || q.size() != 0);
      chk("count", count, q.size());
    end
  end

  logic [7:0] buf_b[8];
  int         buf_n;
  int         acc_cyc[8];

  task automatic push_buf();
    int  idx = 0;
    int  n = 0;
    bit  acc;
    valid  = 1'b1;
    letter = buf_b[0];
    while (idx < buf_n && n < 500) begin
      acc = ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (idx < buf_n) letter = buf_b[idx];
      else valid = 1'b0;
    end
    valid = 1'b0;
    chk("push_timeout", idx, buf_n);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp1[10];
    int         hexp[10];
    logic [7:0] msg[6];
    int         t0;
    bit         saw21;

    exp1 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    hexp = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 1};
    msg  = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20};

    // Reset with random inputs, checked before any clock edge.
    rst = 1'b1;
    valid = 1'($urandom); letter = 8'($urandom);
    valid1 = 1'($urandom); letter1 = 8'($urandom);
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_tx1", tx1, 1'b1);
    chk("rst_count1", count1, 0);
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b0; valid1 = 1'b0; rst = 1'b0;

    // One clock per bit: 0x55 alternates across the whole frame.
    valid1 = 1'b1; letter1 = 8'h55;
    @(posedge clk); #1;
    valid1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("cpb1_tx", tx1, exp1[i]);
    end
    chk("cpb1_busy_end", busy1, 1'b1);
    @(posedge clk); #1;
    chk("cpb1_idle", busy1, 1'b0);
    chk("cpb1_tx_idle", tx1, 1'b1);

    // Single 'H': start bit, bits 0,0,0,1,0,0,1,0, stop; busy drops at N+41.
    valid = 1'b1; letter = 8'h48;
    @(posedge clk); #1;
    valid = 1'b0;
    // hexp holds start, d0..d7 and stop in transmit order.
    hexp = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("h_tx", tx, hexp[i/4]);
    end
    chk("h_busy_stop", busy, 1'b1);
    @(posedge clk); #1;
    chk("h_busy_fall", busy, 1'b0);
    chk("h_tx_idle", tx, 1'b1);

    // Burst "Hello ": five consecutive pushes fill the FIFO, frames chain with no gap.
    repeat (3) begin @(posedge clk); #1; end
    sent.delete();
    for (int i = 0; i < 6; i++) buf_b[i] = msg[i];
    buf_n = 6;
    push_buf();
    t0 = acc_cyc[0];
    chk("burst_5th_edge", acc_cyc[4] - acc_cyc[0], 4);
    wait_idle(400);
    chk("burst_span", cyc - t0, 241);
    chk("burst_sent_n", sent.size(), 6);
    for (int i = 0; i < 6 && i < sent.size(); i++) chk("burst_sent", sent[i], msg[i]);

    // Full FIFO: a held 0x21 is dropped.
    repeat (3) begin @(posedge clk); #1; end
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      do buf_b[i] = 8'($urandom); while (buf_b[i] == 8'h21);
    end
    buf_n = 5;
    push_buf();
    chk("full_count", count, 4);
    chk("full_ready", ready, 1'b0);
    valid = 1'b1; letter = 8'h21;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("drop_count", count, 4);
    end
    valid = 1'b0;
    wait_idle(400);
    saw21 = 1'b0;
    foreach (sent[i]) if (sent[i] == 8'h21) saw21 = 1'b1;
    chk("drop_sent_n", sent.size(), 5);
    chk("drop_no_21", saw21, 1'b0);

    // Reset during data bit 3 with two letters queued.
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) buf_b[i] = 8'($urandom);
    buf_n = 3;
    push_buf();
    repeat (16) @(posedge clk);
    #1;
    chk("pre_rst_count", count, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    #3;
    rst = 1'b0;
    sent.delete();
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_tx", tx, 1'b1);
    buf_b[0] = 8'h6f;
    buf_n = 1;
    push_buf();
    wait_idle(100);
    chk("post_rst_sent_n", sent.size(), 1);
    if (sent.size() > 0) chk("post_rst_sent", sent[0], 8'h6f);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      valid  = ($urandom_range(0, 3) == 0);
      letter = 8'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
